sdf_r2_butterfly_stage: RTL and testbench

- Radix-2 single-path delay-feedback (SDF) butterfly stage for the streaming 128-point FFT.
- Takes a gapless complex sample stream and produces butterfly outputs in SDF order, using a feedback delay line of depth D = NFFT/2^STAGE_NO.
- Drives Twiddle_active to the same stage's twiddle address generator. Its outputs feed that stage's twiddle multiplier.
- One instance per stage. STAGE_NO matches the paired address generator.

---
 rtl/sdf_r2_butterfly_stage.sv | 211 +++++++++++++++++++++
 tb/tb_sdf_r2_butterfly_stage.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdf_r2_butterfly_stage.sv
// ---------------------------------------------------------------------------
// sdf_r2_butterfly_stage
//   Radix-2 single-path delay-feedback butterfly stage of the streaming FFT.
//   A gapless frame of NFFT complex samples enters; NFFT butterfly results
//   leave in SDF order (D sums, D diffs, ... , D flushed diffs), with
//   D = NFFT >> STAGE_NO. Twiddle_active pulses one cycle ahead of the first
//   result so the paired twiddle address generator lines up with it.
//
//   Ports
//     clk            rising-edge clock
//     rst            synchronous reset, active low
//     in_valid       sample valid, high for exactly NFFT cycles per frame
//     in_re/in_im    signed input sample, DATA_W bits
//     out_valid      result valid
//     out_re/out_im  signed result, OUT_W bits
//     Twiddle_active one-cycle start pulse for the twiddle address generator
//     frame_err      sticky protocol error (in_valid drop mid-frame, or
//                    in_valid during flush); cleared only by reset
//
//   Optional feature macro: SDF_SCALE_EN
//     defined   : every butterfly result is scaled by (x+1)>>>1, the delay
//                 line and outputs are DATA_W wide (OUT_W = DATA_W)
//     undefined : full growth, OUT_W = DATA_W+1
// ---------------------------------------------------------------------------

// One real component of the butterfly. Purely combinational; the stage
// instantiates one per component (re, im).
module sdf_r2_bf_lane #(
  parameter int DATA_W = 16,
  parameter int OUT_W  = 17
) (
  input  logic                     p1,     // second half of a 2D block
  input  logic                     flush,
  input  logic signed [DATA_W-1:0] b,      // incoming sample
  input  logic signed [OUT_W-1:0]  a,      // value popped from the delay line
  output logic signed [OUT_W-1:0]  push,
  output logic signed [OUT_W-1:0]  res
);
  // a and b both carry DATA_W-bit magnitudes, so DATA_W+1 holds a+b and a-b
  // exactly.
  localparam int SW = DATA_W + 1;

  logic signed [SW-1:0]    a_x, b_x, sum_f, dif_f;
  logic signed [OUT_W-1:0] sum_o, dif_o;

  always_comb begin
    a_x   = SW'(a);
    b_x   = SW'(b);
    sum_f = a_x + b_x;
    dif_f = a_x - b_x;
`ifdef SDF_SCALE_EN
    // (x+1)>>>1 == (x>>>1) + x[0]: round half up without a wider adder.
    // Only a-b = 2^DATA_W-1 (max minus min) exceeds DATA_W after rounding
    // and wraps.
    sum_o = sum_f[SW-1:1] + OUT_W'(sum_f[0]);
    dif_o = dif_f[SW-1:1] + OUT_W'(dif_f[0]);
`else
    sum_o = sum_f;
    dif_o = dif_f;
`endif
    push = OUT_W'(b);   // first half: store the raw sample, sign-extended
    res  = a;           // first half / flush: emit the stored difference
    if (flush) begin
      push = '0;
    end else if (p1) begin
      res  = sum_o;
      push = dif_o;
    end
  end
endmodule

module sdf_r2_butterfly_stage #(
  parameter int NFFT     = 128,
  parameter int STAGE_NO = 1,
  parameter int DATA_W   = 16,
`ifdef SDF_SCALE_EN
  localparam int OUT_W   = DATA_W
`else
  localparam int OUT_W   = DATA_W + 1
`endif
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  output logic signed [OUT_W-1:0]  out_re,
  output logic signed [OUT_W-1:0]  out_im,
  output logic                     Twiddle_active,
  output logic                     frame_err
);
  localparam int LOGN  = $clog2(NFFT);
  localparam int D     = NFFT >> STAGE_NO;
  localparam int LOG2D = LOGN - STAGE_NO;
  localparam int KW    = LOGN + 1;          // k reaches NFFT+D-1 < 2*NFFT

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t          state, state_nx;
  logic [KW-1:0]   k, k_nx;
  logic            abort, flush_err;
  logic            run_cyc, flush_cyc, shift_en, p, bf_vld;

  logic [1:0][DATA_W-1:0] din;
  logic [1:0][OUT_W-1:0]  pop, push, res, s1;
  logic [1:0][OUT_W-1:0]  dl [D];
  logic [1:0]             vld_pipe;

  // ---------------- control ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      k     <= '0;
    end else begin
      state <= state_nx;
      k     <= k_nx;
    end
  end

  // IDLE consumes the first sample itself (as k=0) so a frame is exactly
  // NFFT consecutive in_valid cycles.
  always_comb begin
    state_nx  = state;
    k_nx      = k;
    abort     = 1'b0;
    flush_err = 1'b0;
    case (state)
      IDLE: if (in_valid) begin
        state_nx = RUN;
        k_nx     = KW'(1);
      end
      RUN: begin
        if (!in_valid) begin
          abort    = 1'b1;
          state_nx = IDLE;
          k_nx     = '0;
        end else begin
          k_nx = k + KW'(1);
          if (k == KW'(NFFT - 1)) state_nx = FLUSH;
        end
      end
      FLUSH: begin
        flush_err = in_valid;
        if (k == KW'(NFFT + D - 1)) begin
          state_nx = IDLE;
          k_nx     = '0;
        end else begin
          k_nx = k + KW'(1);
        end
      end
      default: begin
        state_nx = IDLE;
        k_nx     = '0;
      end
    endcase
  end

  assign run_cyc   = in_valid && (state == IDLE || state == RUN);
  assign flush_cyc = (state == FLUSH);
  assign shift_en  = run_cyc || flush_cyc;
  assign p         = k[LOG2D];
  assign bf_vld    = flush_cyc || (run_cyc && (p || k >= KW'(2 * D)));

  // ---------------- datapath ----------------
  assign din = {in_im, in_re};
  assign pop = dl[D-1];

  for (genvar g = 0; g < 2; g++) begin : g_lane
    sdf_r2_bf_lane #(.DATA_W(DATA_W), .OUT_W(OUT_W)) u_lane (
      .p1    (p),
      .flush (flush_cyc),
      .b     (din[g]),
      .a     (pop[g]),
      .push  (push[g]),
      .res   (res[g])
    );
  end

  // Feedback delay line; contents are don't-care outside a frame, so no reset.
  always_ff @(posedge clk) begin
    if (shift_en) begin
      for (int i = D - 1; i > 0; i--) dl[i] <= dl[i-1];
      dl[0] <= push;
    end
  end

  // Two register stages: the extra one lets Twiddle_active (registered off
  // the k=D sample) lead the first result by exactly one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_pipe       <= '0;
      s1             <= '0;
      out_re         <= '0;
      out_im         <= '0;
      Twiddle_active <= 1'b0;
      frame_err      <= 1'b0;
    end else begin
      vld_pipe[0]    <= bf_vld;
      vld_pipe[1]    <= vld_pipe[0] && !abort;
      s1             <= bf_vld ? res : '0;
      out_re         <= (vld_pipe[0] && !abort) ? s1[0] : '0;
      out_im         <= (vld_pipe[0] && !abort) ? s1[1] : '0;
      Twiddle_active <= run_cyc && (k == KW'(D));
      if (abort || flush_err) frame_err <= 1'b1;
    end
  end

  assign out_valid = vld_pipe[1];

endmodule

// File: tb/tb_sdf_r2_butterfly_stage.sv
// Bench for sdf_r2_butterfly_stage: three instances (D=4, D=1, NFFT=128/D=64)
// fed by directed frames; a DIF reference model fills per-instance queues
// that a negedge monitor drains.
module tb_sdf_r2_butterfly_stage;
  localparam int DW = 16;
`ifdef SDF_SCALE_EN
  localparam int OW = 16;
`else
  localparam int OW = 17;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                 iv  [3];
  logic signed [DW-1:0] ir  [3];
  logic signed [DW-1:0] ii  [3];
  logic                 ov  [3];
  logic signed [OW-1:0] ore [3];
  logic signed [OW-1:0] oim [3];
  logic                 tw  [3];
  logic                 fe  [3];

  sdf_r2_butterfly_stage #(.NFFT(8), .STAGE_NO(1), .DATA_W(DW)) u_d4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_re(ir[0]), .in_im(ii[0]),
    .out_valid(ov[0]), .out_re(ore[0]), .out_im(oim[0]),
    .Twiddle_active(tw[0]), .frame_err(fe[0]));

  sdf_r2_butterfly_stage #(.NFFT(8), .STAGE_NO(3), .DATA_W(DW)) u_d1 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_re(ir[1]), .in_im(ii[1]),
    .out_valid(ov[1]), .out_re(ore[1]), .out_im(oim[1]),
    .Twiddle_active(tw[1]), .frame_err(fe[1]));

  sdf_r2_butterfly_stage #(.NFFT(128), .STAGE_NO(1), .DATA_W(DW)) u_n128 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_re(ir[2]), .in_im(ii[2]),
    .out_valid(ov[2]), .out_re(ore[2]), .out_im(oim[2]),
    .Twiddle_active(tw[2]), .frame_err(fe[2]));

  int checks = 0, failures = 0, cyc = 0;
  int exp_re [3][$];
  int exp_im [3][$];
  int vcount [3], twcount [3], exp_tw [3], exp_v [3];
  bit prev_ov [3], prev_tw [3];
  int lat_mark = -1;
  int xr [128], xi [128];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int nfft_of(int u);
    return (u == 2) ? 128 : 8;
  endfunction

  function automatic int d_of(int u);
    return (u == 0) ? 4 : (u == 1) ? 1 : 64;
  endfunction

  function automatic int sc(int x);
`ifdef SDF_SCALE_EN
    return (x + 1) >>> 1;
`else
    return x;
`endif
  endfunction

  task automatic chk(string tag, int got, int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic mon(int u);
    int er, ei;
    if (ov[u]) begin
      vcount[u]++;
      if (!prev_ov[u]) begin
        chk($sformatf("u%0d_twiddle_before_first", u), int'(prev_tw[u]), 1);
        if (u == 1 && lat_mark >= 0) begin
          chk("u1_first_latency", cyc - lat_mark, 2);
          lat_mark = -1;
        end
      end
      if (exp_re[u].size() == 0) begin
        chk($sformatf("u%0d_unexpected_valid_qsize", u), exp_re[u].size(), 1);
      end else begin
        er = exp_re[u].pop_front();
        ei = exp_im[u].pop_front();
        chk($sformatf("u%0d_out_re", u), int'(ore[u]), er);
        chk($sformatf("u%0d_out_im", u), int'(oim[u]), ei);
      end
    end
    if (tw[u]) twcount[u]++;
    prev_ov[u] = ov[u];
    prev_tw[u] = tw[u];
  endtask

  always @(negedge clk) for (int u = 0; u < 3; u++) mon(u);

  // Golden radix-2 DIF stage: per 2D block, D sums then D differences.
  task automatic drive_frame(input int u, input bit extra, input bit mark);
    int n, d, a;
    n = nfft_of(u);
    d = d_of(u);
    for (int b = 0; b < n / (2 * d); b++) begin
      for (int j = 0; j < d; j++) begin
        a = b * 2 * d + j;
        exp_re[u].push_back(sc(xr[a] + xr[a+d]));
        exp_im[u].push_back(sc(xi[a] + xi[a+d]));
      end
      for (int j = 0; j < d; j++) begin
        a = b * 2 * d + j;
        exp_re[u].push_back(sc(xr[a] - xr[a+d]));
        exp_im[u].push_back(sc(xi[a] - xi[a+d]));
      end
    end
    exp_v[u] += n;
    exp_tw[u]++;
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      iv[u] = 1'b1;
      ir[u] = 16'(xr[k]);
      ii[u] = 16'(xi[k]);
      if (mark && k == d) lat_mark = cyc;
    end
    if (extra) begin
      @(posedge clk); #1;
      ir[u] = 16'sd99;
      ii[u] = -16'sd99;
    end
    @(posedge clk); #1;
    iv[u] = 1'b0;
  endtask

  task automatic idle(int c);
    repeat (c) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int u = 0; u < 3; u++) begin
      iv[u] = 1'b0; ir[u] = '0; ii[u] = '0;
      vcount[u] = 0; twcount[u] = 0; exp_tw[u] = 0; exp_v[u] = 0;
    end
    // reset state
    rst = 1'b0;
    idle(3);
    for (int u = 0; u < 3; u++) begin
      chk($sformatf("u%0d_rst_out_valid", u), int'(ov[u]), 0);
      chk($sformatf("u%0d_rst_twiddle", u), int'(tw[u]), 0);
      chk($sformatf("u%0d_rst_frame_err", u), int'(fe[u]), 0);
      chk($sformatf("u%0d_rst_out_re", u), int'(ore[u]), 0);
    end
    rst = 1'b1;
    idle(2);

    // D=4 ramp: expect 6,8,10,12,-4,-4,-4,-4
    for (int k = 0; k < 8; k++) begin xr[k] = k + 1; xi[k] = 0; end
    drive_frame(0, 1'b0, 1'b0);
    idle(12);
    chk("u0_frame_err_clean", int'(fe[0]), 0);

    // D=1 ramp: expect 3,-1,7,-1,11,-1,15,-1, first result 2 edges after "2"
    drive_frame(1, 1'b0, 1'b1);
    idle(6);

    // extremes on D=1
    for (int k = 0; k < 8; k++) begin xr[k] = 32767; xi[k] = -32768; end
    drive_frame(1, 1'b0, 1'b0);
    idle(6);

    // in_valid held into flush: sample ignored, frame_err set, flush intact
    for (int k = 0; k < 8; k++) begin xr[k] = k + 1; xi[k] = 8 - k; end
    drive_frame(1, 1'b1, 1'b0);
    idle(6);
    chk("u1_flush_err_set", int'(fe[1]), 1);
    chk("u0_err_isolated", int'(fe[0]), 0);

    // abort: drop in_valid at k=3 on D=4
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      iv[0] = 1'b1; ir[0] = 16'(k + 1); ii[0] = '0;
    end
    @(posedge clk); #1;
    iv[0] = 1'b0;
    idle(3);
    chk("u0_abort_frame_err", int'(fe[0]), 1);
    chk("u0_abort_out_valid", int'(ov[0]), 0);
    idle(10);
    chk("u0_abort_err_sticky", int'(fe[0]), 1);

    // reset at k=5 of a D=4 frame (twiddle has already fired after k=4)
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      iv[0] = 1'b1; ir[0] = 16'(k + 1); ii[0] = '0;
    end
    @(posedge clk); #1;
    ir[0] = 16'sd6;
    rst   = 1'b0;
    exp_tw[0]++;
    @(posedge clk); #1;
    chk("u0_midrst_out_valid", int'(ov[0]), 0);
    chk("u0_midrst_out_re", int'(ore[0]), 0);
    chk("u0_midrst_out_im", int'(oim[0]), 0);
    chk("u0_midrst_twiddle", int'(tw[0]), 0);
    chk("u0_midrst_frame_err", int'(fe[0]), 0);
    chk("u1_midrst_frame_err", int'(fe[1]), 0);
    rst = 1'b1;
    iv[0] = 1'b0;
    idle(3);
    for (int k = 0; k < 8; k++) begin
      xr[k] = int'($urandom_range(60000)) - 30000;
      xi[k] = int'($urandom_range(60000)) - 30000;
    end
    drive_frame(0, 1'b0, 1'b0);
    idle(12);

    // NFFT=128 back-to-back random frames, 2+ idle cycles after last output
    for (int f = 0; f < 3; f++) begin
      for (int k = 0; k < 128; k++) begin
        xr[k] = int'($urandom_range(60000)) - 30000;
        xi[k] = int'($urandom_range(60000)) - 30000;
      end
      drive_frame(2, 1'b0, 1'b0);
      idle(68);
    end
    idle(10);

    for (int u = 0; u < 3; u++) begin
      chk($sformatf("u%0d_queue_drained", u), exp_re[u].size(), 0);
      chk($sformatf("u%0d_valid_count", u), vcount[u], exp_v[u]);
      chk($sformatf("u%0d_twiddle_count", u), twcount[u], exp_tw[u]);
    end
    chk("u1_latency_seen", lat_mark, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
